// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin sharing of one dual-rail resource port among N users.
// Every port uses return-to-zero handshakes; a user must present a spacer before each request.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   user_input   [N][INPUT] dual-rail request words, one per user
//   user_output  [N][OUTPUT] dual-rail response words, registered; only the owner is non-spacer
//   in           [INPUT] dual-rail word driven to the shared resource, registered
//   out          [OUTPUT] dual-rail response word from the shared resource
//   grant_valid  high while a user owns the resource
//   grant_id     current or last owner
//   timeout_err  (BUS_TIMEOUT_EN only) one-cycle pulse when the resource fails to answer
//
// Optional feature macro: BUS_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on WAIT_RESP.
// Each dual-rail element is a 2-bit rail pair: 00 spacer, 01/10 valid, 11 illegal.

`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif

module bus_rr_arbiter #(
    parameter int N       = 2,
    parameter int INPUT   = `BUS_SIZE,
    parameter int OUTPUT  = `BUS_SIZE,
    parameter int TIMEOUT = 256,
    localparam int IW     = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N-1:0][INPUT-1:0][1:0]  user_input,
    output logic [N-1:0][OUTPUT-1:0][1:0] user_output,
    output logic [INPUT-1:0][1:0]         in,
    input  logic [OUTPUT-1:0][1:0]        out,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_id
`ifdef BUS_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    if (N < 2 || TIMEOUT < 1) begin : g_param_check
        $error("bus_rr_arbiter: requires N >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RESP,
        WAIT_SPACER,
        RELEASE
    } state_t;

    localparam logic [IW:0] NW  = (IW+1)'(N);
    localparam logic [IW:0] ONE = {{IW{1'b0}}, 1'b1};

    state_t                        state, state_d;
    logic [N-1:0]                  armed, armed_d;
    logic [IW-1:0]                 rr, rr_d;
    logic [INPUT-1:0][1:0]         in_d;
    logic [N-1:0][OUTPUT-1:0][1:0] user_output_d;
    logic                          grant_valid_d;
    logic [IW-1:0]                 grant_id_d;

    logic [N-1:0]  u_full, u_spacer;
    logic          out_full, out_spacer;
    logic [N-1:0]  req, rot;
    logic          hit;
    logic [IW-1:0] off, win, rr_next;
    logic [IW:0]   sumw, nxtw;

`ifdef BUS_TIMEOUT_EN
    localparam int           CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt, cnt_d;
    logic          timeout_err_d;
`endif

    // A valid element has exactly one rail high, so XOR of the pair flags it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            u_full[i]   = 1'b1;
            u_spacer[i] = 1'b1;
            for (int j = 0; j < INPUT; j++) begin
                u_full[i]   &= ^user_input[i][j];
                u_spacer[i] &= ~|user_input[i][j];
            end
        end
        out_full   = 1'b1;
        out_spacer = 1'b1;
        for (int j = 0; j < OUTPUT; j++) begin
            out_full   &= ^out[j];
            out_spacer &= ~|out[j];
        end
    end

    // Rotate requests so bit 0 is the rr pointer, pick the lowest set bit,
    // then map back; wrap is done against N so non-power-of-two N works.
    always_comb begin
        req = armed & u_full;
        rot = N'({req, req} >> rr);
        hit = 1'b0;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                hit = 1'b1;
                off = IW'(k);
            end
        end
        sumw = {1'b0, rr} + {1'b0, off};
        if (sumw >= NW) sumw = sumw - NW;
        win  = sumw[IW-1:0];
        nxtw = {1'b0, win} + ONE;
        if (nxtw == NW) nxtw = '0;
        rr_next = nxtw[IW-1:0];
    end

    always_comb begin
        state_d       = state;
        in_d          = in;
        user_output_d = user_output;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        rr_d          = rr;
        armed_d       = armed | u_spacer;
`ifdef BUS_TIMEOUT_EN
        cnt_d         = cnt;
        timeout_err_d = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                // A complete response left on out blocks new grants
                // until the resource returns to spacer.
                if (hit && out_spacer) begin
                    in_d          = user_input[win];
                    grant_id_d    = win;
                    grant_valid_d = 1'b1;
                    armed_d[win]  = 1'b0;
                    rr_d          = rr_next;
                    state_d       = WAIT_RESP;
`ifdef BUS_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            WAIT_RESP: begin
                if (out_full) begin
                    user_output_d[grant_id] = out;
                    in_d                    = '0;
                    state_d                 = WAIT_SPACER;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt == TLAST) begin
                    timeout_err_d = 1'b1;
                    in_d          = '0;
                    state_d       = WAIT_SPACER;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
`endif
            end
            WAIT_SPACER: begin
                if (out_spacer) state_d = RELEASE;
            end
            RELEASE: begin
                if (u_spacer[grant_id]) begin
                    user_output_d[grant_id] = '0;
                    grant_valid_d           = 1'b0;
                    state_d                 = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            in          <= '0;
            user_output <= '0;
            grant_valid <= 1'b0;
            grant_id    <= IW'(N - 1);
            armed       <= '0;
            rr          <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            in          <= in_d;
            user_output <= user_output_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            armed       <= armed_d;
            rr          <= rr_d;
`ifdef BUS_TIMEOUT_EN
            cnt         <= cnt_d;
            timeout_err <= timeout_err_d;
`endif
        end
    end

endmodule
